// File: rtl/pmp_pkg.sv
// Shared types for the PMP access checker.
package pmp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_mode_e;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    EXEC  = 2'd2
  } pmp_acc_e;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  // Encoding 3 of the request type is treated as a read.
  function automatic pmp_acc_e decode_acc(input logic [1:0] req_type);
    unique case (req_type)
      2'd1:    return WRITE;
      2'd2:    return EXEC;
      default: return READ;
    endcase
  endfunction

  // Access length minus one; size encoding 3 is treated as a word.
  function automatic logic [33:0] size_m1(input logic [1:0] size);
    unique case (size)
      2'd0:    return 34'd0;
      2'd1:    return 34'd1;
      default: return 34'd3;
    endcase
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Classifies one access range against one PMP entry's region.
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [33:0] acc_start_i,
  input  logic [33:0] acc_end_i,
  input  pmp_cfg_t    cfg_i,
  input  logic [31:0] pmpaddr_i,
  input  logic [31:0] pmpaddr_prev_i,
  output logic        full_o,
  output logic        partial_o
);

  // Region bounds carry extra headroom so a full-space NAPOT (upper bound 2^35) fits.
  logic [35:0] lo;
  logic [35:0] hi;
  logic        region_en;
  logic [5:0]  ones;
  logic        ones_run;
  logic [31:0] low_mask;
  logic        any_hit;
  logic        all_hit;
  logic        unused_cfg;

  assign unused_cfg = ^{cfg_i.l, cfg_i.rsvd, cfg_i.x, cfg_i.w, cfg_i.r};

  // Derive the region [lo, hi) from the entry's mode.
  always_comb begin
    lo        = '0;
    hi        = '0;
    region_en = 1'b0;
    ones      = '0;
    ones_run  = 1'b1;
    low_mask  = '0;
    unique case (cfg_i.a)
      TOR: begin
        lo        = {2'b00, pmpaddr_prev_i, 2'b00};
        hi        = {2'b00, pmpaddr_i, 2'b00};
        region_en = 1'b1;
      end
      NA4: begin
        lo        = {2'b00, pmpaddr_i, 2'b00};
        hi        = lo + 36'd4;
        region_en = 1'b1;
      end
      NAPOT: begin
        for (int i = 0; i < 32; i++) begin
          if (ones_run && pmpaddr_i[i]) ones = ones + 6'd1;
          else                          ones_run = 1'b0;
        end
        // Shift overflows to zero for ones >= 31, giving an all-ones mask.
        low_mask  = (32'd1 << (ones + 6'd1)) - 32'd1;
        lo        = {2'b00, pmpaddr_i & ~low_mask, 2'b00};
        hi        = lo + (36'd1 << (ones + 6'd3));
        region_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Overlap test on the inclusive access range.
  always_comb begin
    any_hit   = region_en && (lo < hi) && ({2'b00, acc_start_i} < hi) && ({2'b00, acc_end_i} >= lo);
    all_hit   = region_en && (lo < hi) && ({2'b00, acc_start_i} >= lo) && ({2'b00, acc_end_i} < hi);
    full_o    = all_hit;
    partial_o = any_hit && !all_hit;
  end

endmodule

// File: rtl/pmp_checker.sv
// Sequential PMP checker: scans one entry per clock, lowest index first.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [1:0]               req_type,
  input  logic                     req_mmode,
  input  logic [8*NUM_ENTRIES-1:0]  pmpcfg_i,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr_i,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_fault,
  output logic                     resp_matched,
  output logic [IDX_W-1:0]         resp_entry
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] prev_idx;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  pmp_acc_e         acc_q;
  logic             mmode_q;
  logic             fault_q, fault_d;
  logic             matched_q, matched_d;
  logic [IDX_W-1:0] entry_q, entry_d;

  pmp_cfg_t         cur_cfg;
  logic [31:0]      cur_addr;
  logic [31:0]      prev_addr;
  logic [33:0]      acc_start;
  logic [33:0]      acc_end;
  logic             hit_full;
  logic             hit_partial;
  logic             perm_ok;
  logic             accept;
  logic             unused_rsvd;

  assign accept      = (state_q == IDLE) && req_valid;
  assign prev_idx    = idx_q - 1'b1;
  assign cur_cfg     = pmp_cfg_t'(pmpcfg_i[idx_q*8 +: 8]);
  assign cur_addr    = pmpaddr_i[idx_q*32 +: 32];
  // Entry 0 in TOR mode uses a lower bound of zero.
  assign prev_addr   = (idx_q == '0) ? 32'd0 : pmpaddr_i[prev_idx*32 +: 32];
  assign acc_start   = {2'b00, addr_q};
  assign acc_end     = acc_start + size_m1(size_q);
  assign unused_rsvd = ^cur_cfg.rsvd;

  pmp_entry_match u_entry_match (
    .acc_start_i    (acc_start),
    .acc_end_i      (acc_end),
    .cfg_i          (cur_cfg),
    .pmpaddr_i      (cur_addr),
    .pmpaddr_prev_i (prev_addr),
    .full_o         (hit_full),
    .partial_o      (hit_partial)
  );

  // Permission bit selected by access type.
  always_comb begin
    unique case (acc_q)
      WRITE:   perm_ok = cur_cfg.w;
      EXEC:    perm_ok = cur_cfg.x;
      default: perm_ok = cur_cfg.r;
    endcase
  end

  // Next-state and result computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fault_d   = fault_q;
    matched_d = matched_q;
    entry_d   = entry_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (hit_full || hit_partial) begin
          state_d   = RESP;
          matched_d = 1'b1;
          entry_d   = idx_q;
          // Unlocked entries do not constrain machine mode.
          fault_d   = hit_partial ? 1'b1 : ((mmode_q && !cur_cfg.l) ? 1'b0 : !perm_ok);
        end else if (idx_q == LastIdx) begin
          state_d   = RESP;
          matched_d = 1'b0;
          entry_d   = '0;
          fault_d   = !mmode_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d   = IDLE;
          fault_d   = 1'b0;
          matched_d = 1'b0;
          entry_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, scan index and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      fault_q   <= 1'b0;
      matched_q <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fault_q   <= fault_d;
      matched_q <= matched_d;
      entry_q   <= entry_d;
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      acc_q   <= READ;
      mmode_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      acc_q   <= decode_acc(req_type);
      mmode_q <= req_mmode;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_fault   = fault_q;
  assign resp_matched = matched_q;
  assign resp_entry   = entry_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Self-checking bench for pmp_checker with a byte-counting reference model.
module tb_pmp_checker;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic [1:0]    req_type;
  logic          req_mmode;
  logic [8*N-1:0]  pmpcfg;
  logic [32*N-1:0] pmpaddr;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_fault;
  logic          resp_matched;
  logic [3:0]    resp_entry;

  logic [7:0]  cfg_arr [N];
  logic [31:0] addr_arr [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pmpcfg[8*i +: 8]   = cfg_arr[i];
      pmpaddr[32*i +: 32] = addr_arr[i];
    end
  end

  pmp_checker #(.NUM_ENTRIES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_type     (req_type),
    .req_mmode    (req_mmode),
    .pmpcfg_i     (pmpcfg),
    .pmpaddr_i    (pmpaddr),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_fault   (resp_fault),
    .resp_matched (resp_matched),
    .resp_entry   (resp_entry)
  );

  // Reference: count bytes of the access inside each entry's region.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                                input logic mm, output logic f, output logic m, output int e);
    longint unsigned n, lo, hi, base, cnt, byte_addr;
    int mode, k;
    logic perm;
    n = 64'd1 << ((sz == 2'd3) ? 2 : int'(sz));
    f = !mm;
    m = 1'b0;
    e = 0;
    for (int i = 0; i < N; i++) begin
      mode = int'(cfg_arr[i][4:3]);
      lo = 0;
      hi = 0;
      if (mode == 0) continue;
      if (mode == 1) begin
        lo = (i == 0) ? 64'd0 : 64'(addr_arr[i-1]) * 4;
        hi = 64'(addr_arr[i]) * 4;
      end else if (mode == 2) begin
        lo = 64'(addr_arr[i]) * 4;
        hi = lo + 4;
      end else begin
        k = 0;
        while (k < 32 && addr_arr[i][k]) k++;
        base = (64'(addr_arr[i]) >> (k + 1)) << (k + 1);
        lo = base * 4;
        hi = lo + (64'd1 << (k + 3));
      end
      cnt = 0;
      for (longint unsigned b = 0; b < n; b++) begin
        byte_addr = 64'(a) + b;
        if (byte_addr >= lo && byte_addr < hi) cnt++;
      end
      if (cnt == 0) continue;
      m = 1'b1;
      e = i;
      perm = (ty == 2'd1) ? cfg_arr[i][1] : (ty == 2'd2) ? cfg_arr[i][2] : cfg_arr[i][0];
      if (cnt < n)                    f = 1'b1;
      else if (mm && !cfg_arr[i][7]) f = 1'b0;
      else                            f = !perm;
      return;
    end
  endfunction

  // Drive one request and wait (bounded) for its response; lat = -1 on timeout.
  task automatic run_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                         input logic mm, output logic f, output logic m, output int e,
                         output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_type  = ty;
    req_mmode = mm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= N + 4; c++) begin
      if (resp_valid) break;
      @(posedge clk);
      #1;
      if (resp_valid) lat = c;
    end
    f = resp_fault;
    m = resp_matched;
    e = int'(resp_entry);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_arr[i]  = 8'h00;
      addr_arr[i] = 32'h0;
    end
  endtask

  // Run a request and compare {fault, matched, entry, latency} to expectations.
  task automatic expect_req(input string name, input logic [31:0] a, input logic [1:0] sz,
                            input logic [1:0] ty, input logic mm, input logic ef,
                            input logic em, input int ee, input int elat);
    logic f, m;
    int e, lat;
    run_req(a, sz, ty, mm, f, m, e, lat);
    finish_resp();
    checks++;
    if ({f, m, 8'(e), 16'(lat)} !== {ef, em, 8'(ee), 16'(elat)}) begin
      errors++;
      $display("FAIL %s: got fault=%0b matched=%0b entry=%0d lat=%0d, want fault=%0b matched=%0b entry=%0d lat=%0d",
               name, f, m, e, lat, ef, em, ee, elat);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({resp_valid, resp_fault, resp_matched, resp_entry} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {resp_valid, resp_fault, resp_matched, resp_entry});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_napot();
    clear_cfg();
    cfg_arr[0]  = 8'h1B;
    addr_arr[0] = 32'h2000_01FF;
    expect_req("napot_read_top", 32'h8000_0FFC, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1);
    expect_req("napot_exec", 32'h8000_0000, 2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 0, 1);
    expect_req("napot_partial", 32'h8000_0FFE, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 0, 1);
  endtask

  task automatic test_no_match();
    clear_cfg();
    expect_req("nomatch_mmode", 32'h0000_1234, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 0, N);
    expect_req("nomatch_umode", 32'h0000_1234, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 0, N);
  endtask

  task automatic test_tor();
    clear_cfg();
    addr_arr[2] = 32'h0400_0000;
    addr_arr[3] = 32'h0400_1000;
    cfg_arr[3]  = 8'h0D;
    expect_req("tor_read", 32'h1000_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3, 4);
    expect_req("tor_write", 32'h1000_0000, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 3, 4);
  endtask

  task automatic test_lock();
    clear_cfg();
    cfg_arr[0]  = 8'h98;
    addr_arr[0] = 32'h2000_01FF;
    expect_req("locked_mread", 32'h8000_0010, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1, 0, 1);
    cfg_arr[0] = 8'h18;
    expect_req("unlocked_mread", 32'h8000_0010, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 0, 1);
  endtask

  task automatic test_backpressure();
    logic f, m;
    int e, lat;
    logic unstable;
    clear_cfg();
    cfg_arr[0]  = 8'h1B;
    addr_arr[0] = 32'h2000_01FF;
    resp_ready = 1'b0;
    run_req(32'h8000_0100, 2'd2, 2'd2, 1'b0, f, m, e, lat);
    unstable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_fault !== f ||
          resp_matched !== m || int'(resp_entry) != e) unstable = 1'b1;
    end
    checks++;
    if (unstable !== 1'b0 || {f, m, 8'(e), 16'(lat)} !== {1'b1, 1'b1, 8'd0, 16'd1}) begin
      errors++;
      $display("FAIL backpressure_hold: unstable=%0b fault=%0b matched=%0b entry=%0d lat=%0d, want unstable=0 1/1/0/1",
               unstable, f, m, e, lat);
    end
    finish_resp();
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got valid/ready=%b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid_scan();
    logic stale;
    clear_cfg();
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_size  = 2'd2;
    req_type  = 2'd0;
    req_mmode = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset_valid: got %b want 0", resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midscan_reset_ready: got %b want 1", req_ready);
    end
    stale = 1'b0;
    repeat (2 * N) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL midscan_no_stale: got stale=%b want 0", stale);
    end
    expect_req("after_reset", 32'h0000_0040, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 0, N);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz, ty;
    logic        mm, ef, em;
    int          ee;
    string       nm;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int v, t;
        v = int'($urandom_range(32'h100, 32'h140));
        t = int'($urandom_range(0, 5));
        v = (v & ~((1 << (t + 1)) - 1)) | ((1 << t) - 1);
        addr_arr[i] = 32'(v);
        cfg_arr[i]  = {($urandom_range(0, 3) == 0), 2'b00, 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7))};
      end
      if (r[0]) begin
        addr_arr[N-1] = 32'hFFFF_FFFF;
        cfg_arr[N-1]  = 8'h19;
      end
      for (int q = 0; q < 25; q++) begin
        if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
        else                            a = 32'($urandom_range(32'h3F0, 32'h510));
        sz = 2'($urandom_range(0, 3));
        ty = 2'($urandom_range(0, 3));
        mm = 1'($urandom_range(0, 1));
        model(a, sz, ty, mm, ef, em, ee);
        nm = $sformatf("random_r%0d_q%0d_a%08h", r, q, a);
        expect_req(nm, a, sz, ty, mm, ef, em, ee, em ? ee + 1 : N);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_type   = '0;
    req_mmode  = 1'b0;
    resp_ready = 1'b1;
    clear_cfg();
    test_reset();
    test_napot();
    test_no_match();
    test_tor();
    test_lock();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
